// File: rtl/memin_arbiter.sv
// memin_arbiter: round-robin arbiter sharing the single-port memin matrix memory between
// two requesters with registered grants and bounded bursts.
//
//   Port 0 (host loader) writes operand words; port 1 (multiply sequencer) reads A/B operands.
//   Only one port owns the memory at a time. The owner gets one beat per cycle while it keeps
//   requesting. After MAXBURST beats it hands over if the other port is waiting.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   reqN, weN            port N request (held until accepted) and write (1) / read (0)
//   addrN, wdataN        port N address and write data
//   gntN                 port N owns the memory (registered)
//   rvalidN              rdata holds the result of port N's read from the previous cycle
//   mem_en, mem_we       memory access strobe and write enable
//   mem_addr, mem_wdata  memory address and write data
//   mem_rdata            memory read data, valid one cycle after a read strobe
//   rdata                mem_rdata passed through to both ports
module memin_arbiter #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] BurstMax = CW'(MAXBURST);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          lp_q, lp_d;        // last owner; the other port wins a tie from idle
  logic [CW-1:0] cnt_q, cnt_d;      // beats accepted in the current burst
  logic          rvalid0_q, rvalid1_q;

  logic          beat0, beat1;
  logic          own1;
  logic          own_req, oth_req;
  state_e        oth_state;
  logic [CW-1:0] cnt_inc;

  // Grants come straight from the state register, so they are registered and exclusive.
  assign gnt0  = (state_q == StOwn0);
  assign gnt1  = (state_q == StOwn1);
  assign beat0 = req0 & gnt0;
  assign beat1 = req1 & gnt1;

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    lp_d      = lp_q;
    cnt_d     = cnt_q;
    own1      = (state_q == StOwn1);
    own_req   = own1 ? req1 : req0;
    oth_req   = own1 ? req0 : req1;
    oth_state = own1 ? StOwn0 : StOwn1;
    cnt_inc   = cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        // On a tie, lp_q = 1 means port 1 went last, so port 0 wins.
        if (req0 && (!req1 || lp_q)) begin
          state_d = StOwn0;
          lp_d    = 1'b0;
          cnt_d   = '0;
        end else if (req1) begin
          state_d = StOwn1;
          lp_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      StOwn0, StOwn1: begin
        if (!own_req) begin
          // Owner released: hand over directly if the other side waits, no idle gap.
          if (oth_req) begin
            state_d = oth_state;
            lp_d    = ~own1;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_inc == BurstMax) begin
          // Burst limit hit on this beat: force a hand-over only if someone is waiting,
          // otherwise start a fresh burst for the same owner.
          cnt_d = '0;
          if (oth_req) begin
            state_d = oth_state;
            lp_d    = ~own1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lp_q      <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lp_q      <= lp_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= beat0 & ~we0;
      rvalid1_q <= beat1 & ~we1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = mem_rdata;

  // ---------------------------------------------------------------------------------------
  // Memory-side mux: driven from the accepted beat, all zero otherwise
  // ---------------------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (beat1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

endmodule

// File: tb/tb_memin_arbiter.sv
// Testbench for memin_arbiter: vector table, directed corner sequences and random traffic,
// all checked against a behavioural ownership/memory model kept in the bench.
module tb_memin_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] tbmem [32];

  always #5 clk = ~clk;

  memin_arbiter #(.AW(AW), .DW(DW), .MAXBURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata)
  );

  // memin stand-in: synchronous read, one-cycle latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Model: who owns memory (-1 nobody), who went last, beats in the current run.
  int            m_own  = -1;
  int            m_last = 1;
  int            m_run  = 0;
  bit            m_rv [2];
  logic [DW-1:0] m_rexp = '0;
  logic [DW-1:0] mmem [32];
  bit            last_bt [2];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic take(input int n);
    m_own  = n;
    m_last = n;
    m_run  = 0;
  endtask

  // Compare every output with the model for this cycle, advance the model, go to next cycle.
  task automatic tick(input string tag);
    bit            rq [2];
    bit            w  [2];
    logic [AW-1:0] a  [2];
    logic [DW-1:0] d  [2];
    bit            bt [2];
    bit            e_en;
    int            sel;
    int            o;
    int            nw;
    rq = '{req0, req1};
    w  = '{we0, we1};
    a  = '{addr0, addr1};
    d  = '{wdata0, wdata1};
    #1;
    bt[0] = (m_own == 0) && rq[0];
    bt[1] = (m_own == 1) && rq[1];
    e_en  = bt[0] || bt[1];
    sel   = bt[0] ? 0 : 1;
    chk1({tag, " gnt0"}, gnt0, m_own == 0);
    chk1({tag, " gnt1"}, gnt1, m_own == 1);
    chk1({tag, " excl"}, gnt0 && gnt1, 1'b0);
    chk1({tag, " mem_en"}, mem_en, e_en);
    chk1({tag, " mem_we"}, mem_we, e_en && w[sel]);
    chk8({tag, " mem_addr"}, 8'(mem_addr), e_en ? 8'(a[sel]) : 8'h00);
    chk8({tag, " mem_wdata"}, mem_wdata, e_en ? d[sel] : 8'h00);
    chk1({tag, " rvalid0"}, rvalid0, m_rv[0]);
    chk1({tag, " rvalid1"}, rvalid1, m_rv[1]);
    if (m_rv[0] || m_rv[1]) chk8({tag, " rdata"}, rdata, m_rexp);

    if (e_en) begin
      if (w[sel]) mmem[a[sel]] = d[sel];
      else        m_rexp = mmem[a[sel]];
    end
    last_bt = bt;
    if (rst) begin
      m_own = -1; m_last = 1; m_run = 0; m_rv = '{1'b0, 1'b0};
    end else begin
      m_rv[0] = bt[0] && !w[0];
      m_rv[1] = bt[1] && !w[1];
      if (m_own < 0) begin
        if (rq[0] && rq[1]) nw = (m_last == 0) ? 1 : 0;
        else if (rq[0])     nw = 0;
        else if (rq[1])     nw = 1;
        else                nw = -1;
        if (nw >= 0) take(nw);
      end else begin
        o = 1 - m_own;
        if (!rq[m_own]) begin
          if (rq[o]) take(o);
          else m_own = -1;
        end else begin
          m_run++;
          // A run that has used a whole number of bursts yields to a waiting port.
          if ((m_run % MB) == 0 && rq[o]) take(o);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  task automatic gen_port(input int p);
    bit            cur;
    bit            r;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cur = (p == 0) ? req0 : req1;
    if (!cur || last_bt[p]) begin
      r = ($urandom_range(3) != 0);
      w = ($urandom_range(1) != 0);
      a = AW'($urandom_range(17));
      d = DW'($urandom);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    end else if ($urandom_range(15) == 0) begin
      // Withdraw a request that has not been granted yet
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end
  endtask

  typedef struct {
    int r0, w0, a0, d0, r1, w1, a1, d1;
    int g0, g1, en, we, ad, v0, v1, rd;
  } vec_t;

  vec_t vt [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit got;
    for (int i = 0; i < 32; i++) begin
      tbmem[i] = '0;
      mmem[i]  = '0;
    end
    m_rv = '{1'b0, 1'b0};
    last_bt = '{1'b0, 1'b0};
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    vt[0] = '{1, 1, 3, 'h11, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 1, 3, 'h11, 0, 0, 0, 0,     1, 0, 1, 1, 3, 0, 0, 0};
    vt[2] = '{1, 0, 3, 0,    0, 0, 0, 0,     1, 0, 1, 0, 3, 0, 0, 0};
    vt[3] = '{0, 0, 0, 0,    1, 0, 3, 0,     1, 0, 0, 0, 0, 1, 0, 'h11};
    vt[4] = '{0, 0, 0, 0,    1, 0, 3, 0,     0, 1, 1, 0, 3, 0, 0, 0};
    vt[5] = '{0, 0, 0, 0,    0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 1, 'h11};
    vt[6] = '{1, 1, 4, 'h22, 1, 1, 5, 'h33,  0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 7; i < 11; i++)  vt[i] = '{1, 1, 4, 'h22, 1, 1, 5, 'h33, 1, 0, 1, 1, 4, 0, 0, 0};
    for (int i = 11; i < 15; i++) vt[i] = '{1, 1, 4, 'h22, 1, 1, 5, 'h33, 0, 1, 1, 1, 5, 0, 0, 0};
    vt[15] = vt[7];

    do_reset();
    for (int i = 0; i < 16; i++) begin
      req0 = vt[i].r0 != 0; we0 = vt[i].w0 != 0; addr0 = AW'(vt[i].a0); wdata0 = DW'(vt[i].d0);
      req1 = vt[i].r1 != 0; we1 = vt[i].w1 != 0; addr1 = AW'(vt[i].a1); wdata1 = DW'(vt[i].d1);
      #1;
      chk1($sformatf("vec%0d gnt0", i), gnt0, vt[i].g0 != 0);
      chk1($sformatf("vec%0d gnt1", i), gnt1, vt[i].g1 != 0);
      chk1($sformatf("vec%0d mem_en", i), mem_en, vt[i].en != 0);
      chk1($sformatf("vec%0d mem_we", i), mem_we, vt[i].we != 0);
      chk8($sformatf("vec%0d mem_addr", i), 8'(mem_addr), 8'(vt[i].ad));
      chk1($sformatf("vec%0d rvalid0", i), rvalid0, vt[i].v0 != 0);
      chk1($sformatf("vec%0d rvalid1", i), rvalid1, vt[i].v1 != 0);
      if (vt[i].v0 != 0 || vt[i].v1 != 0) chk8($sformatf("vec%0d rdata", i), rdata, 8'(vt[i].rd));
      tick("vec");
    end

    // ---------------- reset mid-burst, read in the reset cycle ----------------
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h55;
    tick("rstmid");
    tick("rstmid");
    tick("rstmid");
    we0 = 1'b0;
    rst = 1'b1;
    tick("rstmid");
    rst = 1'b0;
    idle_inputs();
    #1;
    chk1("rstmid gnt0 dropped", gnt0, 1'b0);
    chk1("rstmid mem_en", mem_en, 1'b0);
    chk1("rstmid rvalid0 cancelled", rvalid0, 1'b0);
    tick("rstmid");
    req0 = 1'b1; req1 = 1'b1;
    tick("rstmid tie");
    #1;
    chk1("rstmid tie gnt0", gnt0, 1'b1);
    chk1("rstmid tie gnt1", gnt1, 1'b0);
    tick("rstmid tie");

    // ---------------- lone writer, 18 beats ----------------
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = '0; wdata0 = 8'd1;
    #1;
    chk1("lone gnt0 latency", gnt0, 1'b0);
    tick("lone");
    for (int i = 0; i < 18; i++) begin
      addr0 = AW'(i); wdata0 = DW'(i + 1);
      #1;
      chk1($sformatf("lone%0d gnt0", i), gnt0, 1'b1);
      chk1($sformatf("lone%0d gnt1", i), gnt1, 1'b0);
      chk1($sformatf("lone%0d mem_en", i), mem_en, 1'b1);
      chk8($sformatf("lone%0d mem_addr", i), 8'(mem_addr), 8'(i));
      chk8($sformatf("lone%0d mem_wdata", i), mem_wdata, 8'(i + 1));
      tick("lone");
    end

    // ---------------- read latency on port 1 ----------------
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd5; wdata1 = 8'h2A;
    tick("rdlat");
    tick("rdlat");
    we1 = 1'b0;
    tick("rdlat");
    req1 = 1'b0;
    #1;
    chk1("rdlat rvalid1", rvalid1, 1'b1);
    chk8("rdlat rdata", rdata, 8'h2A);
    chk1("rdlat rvalid0", rvalid0, 1'b0);
    tick("rdlat");

    // ---------------- early release hands over with no idle cycle ----------------
    do_reset();
    req0 = 1'b1; addr0 = 5'd1; req1 = 1'b1; addr1 = 5'd2;
    tick("early");
    tick("early");
    tick("early");
    req0 = 1'b0;
    tick("early");
    #1;
    chk1("early gnt1", gnt1, 1'b1);
    chk1("early gnt0", gnt0, 1'b0);
    tick("early");
    idle_inputs();
    tick("early");

    // ---------------- no starvation after a long lone run ----------------
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd9; wdata1 = 8'h77;
    tick("starve");
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1($sformatf("starve%0d gnt1", i), gnt1, 1'b1);
      tick("starve");
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
    nb = 0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (gnt0) got = 1'b1;
      else begin
        if (mem_en) nb++;
        tick("starve");
      end
    end
    chk1("starve gnt0 reached", got, 1'b1);
    chk8("starve port1 beats", 8'(nb), 8'(MB - (10 % MB)));
    idle_inputs();
    tick("starve");

    // ---------------- random traffic ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      gen_port(0);
      gen_port(1);
      tick("rand");
    end
    rst = 1'b0;
    idle_inputs();
    tick("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
